// File: rtl/bist_pkg.sv
// Shared types and constants for the truth-table BIST sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } bist_state_t;

  localparam logic [7:0] SILLY_EXPECTED = 8'hCE;

  // Cycles from the accepting start edge to the edge that raises done.
  function automatic int run_cycles(input int n_in, input int settle);
    return (32'sd1 <<< n_in) * (settle + 32'sd2);
  endfunction

endpackage

// File: rtl/bist_sat_counter.sv
// Clearable, saturating up-counter used for the mismatch tally.
module bist_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear has priority; increments stop at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sillyfunction_bist_ctrl.sv
// Walks every input vector onto an N_IN-input combinational block and checks
// its output against a golden truth table, reporting pass/fail and first failure.
module sillyfunction_bist_ctrl
  import bist_pkg::*;
#(
  parameter int                      N_IN       = 3,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED   = SILLY_EXPECTED,
  parameter int                      SETTLE_CYC = 2,
  parameter int                      ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  localparam int              SW          = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);
  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);

  bist_state_t     state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;

  logic            in_run;
  logic            abort_run;
  logic            mismatch;
  logic            err_clr;
  logic            err_inc;

  assign in_run    = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign abort_run = abort && in_run;
  // Case inequality so an undriven/X output from the block under test fails.
  assign mismatch  = (state_q == CHECK) && (dut_y !== EXPECTED[vec_q]);
  assign err_inc   = mismatch && !abort_run;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    dut_in_d = dut_in_q;
    pass_d   = pass_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    err_clr  = 1'b0;

    if (abort_run) begin
      state_d  = IDLE;
      vec_d    = '0;
      settle_d = '0;
      dut_in_d = '0;
      pass_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && !abort) begin
            state_d  = APPLY;
            vec_d    = '0;
            settle_d = '0;
            dut_in_d = '0;
            pass_d   = 1'b0;
            ffv_d    = 1'b0;
            ffvec_d  = '0;
            err_clr  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        APPLY: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = CHECK;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SETTLE_ONE;
          end
        end
        CHECK: begin
          if (mismatch && !ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end else begin
            ffv_d   = ffv_q;
          end
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            // Counter saturates, so zero now and no miss here means a clean run.
            pass_d  = (err_count == '0) && !mismatch;
          end else begin
            state_d  = APPLY;
            vec_d    = vec_q + VEC_ONE;
            dut_in_d = vec_q + VEC_ONE;
          end
        end
        default: begin
          state_d  = IDLE;
          vec_d    = '0;
          settle_d = '0;
          dut_in_d = '0;
        end
      endcase
    end

    busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
    end
  end

  bist_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (err_inc),
    .count (err_count)
  );

  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_sillyfunction_bist_ctrl.sv
// Directed-vector bench for sillyfunction_bist_ctrl with a behavioural
// sillyfunction model (y = b | ~a&c) plus stuck-at and inverted variants.
module tb_sillyfunction_bist_ctrl;

  localparam int RUN = 32;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic       dut_y, dut_y2;
  logic [2:0] dut_in, dut_in2;
  logic       busy, done, pass, ffv;
  logic       busy2, done2, pass2, ffv2;
  logic [3:0] err;
  logic [1:0] err2;
  logic [2:0] ffvec, ffvec2;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;  // 0 good, 1 stuck-at-0, 2 stuck-at-1

  always #5 clk = ~clk;

  function automatic logic silly(input logic [2:0] v);
    return v[1] | (~v[2] & v[0]);
  endfunction

  always_comb begin
    case (mode)
      1:       dut_y = 1'b0;
      2:       dut_y = 1'b1;
      default: dut_y = silly(dut_in);
    endcase
  end

  assign dut_y2 = ~silly(dut_in2);

  sillyfunction_bist_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  sillyfunction_bist_ctrl #(.ERR_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in2), .dut_y(dut_y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
    vectors++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); miscompares++; end
    vectors++; if (pass !== 1'b0) begin $display("FAIL reset_pass: got %b want 0", pass); miscompares++; end
    vectors++; if (err !== 4'd0) begin $display("FAIL reset_err: got %0d want 0", err); miscompares++; end
    vectors++; if ({ffv, ffvec} !== 4'd0) begin $display("FAIL reset_ff: got %b want 0000", {ffv, ffvec}); miscompares++; end
    vectors++; if (dut_in !== 3'd0) begin $display("FAIL reset_dut_in: got %0d want 0", dut_in); miscompares++; end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_good_run();
    logic [2:0] exp_in;
    mode = 0;
    pulse_start();
    for (int k = 0; k < RUN; k++) begin
      exp_in = 3'(k / 4);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || dut_in !== exp_in) begin
        $display("FAIL good_walk[%0d]: got busy=%b done=%b dut_in=%0d want busy=1 done=0 dut_in=%0d",
                 k, busy, done, dut_in, exp_in);
        miscompares++;
      end
      tick();
    end
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin $display("FAIL good_done: got done=%b busy=%b want 1 0", done, busy); miscompares++; end
    vectors++; if (pass !== 1'b1) begin $display("FAIL good_pass: got %b want 1", pass); miscompares++; end
    vectors++; if (err !== 4'd0) begin $display("FAIL good_err: got %0d want 0", err); miscompares++; end
    vectors++; if (ffv !== 1'b0) begin $display("FAIL good_ffv: got %b want 0", ffv); miscompares++; end
    vectors++; if (done2 !== 1'b1 || pass2 !== 1'b0) begin $display("FAIL sat_done_pass: got done=%b pass=%b want 1 0", done2, pass2); miscompares++; end
    vectors++; if (err2 !== 2'd3) begin $display("FAIL sat_err: got %0d want 3", err2); miscompares++; end
    vectors++; if (ffv2 !== 1'b1 || ffvec2 !== 3'd0) begin $display("FAIL sat_ff: got valid=%b vec=%0d want 1 0", ffv2, ffvec2); miscompares++; end
  endtask

  task automatic test_stuck(input int m, input logic [3:0] exp_err, input logic [2:0] exp_vec);
    int n;
    mode = m;
    pulse_start();
    wait_done(n);
    vectors++; if (n !== RUN) begin $display("FAIL stuck%0d_cycles: got %0d want %0d", m, n, RUN); miscompares++; end
    vectors++; if (err !== exp_err) begin $display("FAIL stuck%0d_err: got %0d want %0d", m, err, exp_err); miscompares++; end
    vectors++; if (ffv !== 1'b1 || ffvec !== exp_vec) begin $display("FAIL stuck%0d_ff: got valid=%b vec=%0d want 1 %0d", m, ffv, ffvec, exp_vec); miscompares++; end
    vectors++; if (pass !== 1'b0) begin $display("FAIL stuck%0d_pass: got %b want 0", m, pass); miscompares++; end
  endtask

  task automatic test_restart_from_done();
    int n;
    mode = 0;
    pulse_start();
    vectors++; if (done !== 1'b0 || busy !== 1'b1) begin $display("FAIL restart_flags: got done=%b busy=%b want 0 1", done, busy); miscompares++; end
    vectors++; if (err !== 4'd0 || ffv !== 1'b0) begin $display("FAIL restart_clear: got err=%0d ffv=%b want 0 0", err, ffv); miscompares++; end
    wait_done(n);
    vectors++; if (n !== RUN - 0 || pass !== 1'b1) begin $display("FAIL restart_run: got cycles=%0d pass=%b want %0d 1", n, pass, RUN); miscompares++; end
  endtask

  task automatic test_abort();
    int n;
    mode = 1;
    pulse_start();
    n = 0;
    while (dut_in !== 3'd3 && n < 100) begin
      tick();
      n++;
    end
    vectors++; if (n !== 12) begin $display("FAIL abort_reach3: got %0d cycles want 12", n); miscompares++; end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done); miscompares++; end
    vectors++; if (dut_in !== 3'd0) begin $display("FAIL abort_dut_in: got %0d want 0", dut_in); miscompares++; end
    vectors++; if (err !== 4'd2 || ffv !== 1'b1 || ffvec !== 3'd1) begin $display("FAIL abort_keep: got err=%0d ffv=%b vec=%0d want 2 1 1", err, ffv, ffvec); miscompares++; end
    tick(); tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done); miscompares++; end
    mode = 0;
    pulse_start();
    wait_done(n);
    vectors++; if (n !== RUN || pass !== 1'b1 || err !== 4'd0) begin $display("FAIL abort_rerun: got cycles=%0d pass=%b err=%0d want %0d 1 0", n, pass, err, RUN); miscompares++; end
  endtask

  task automatic test_start_ignored();
    int n;
    mode = 0;
    pulse_start();
    n = 0;
    while (dut_in !== 3'd5 && n < 100) begin
      tick();
      n++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n++;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    vectors++; if (n !== RUN) begin $display("FAIL midstart_cycles: got %0d want %0d", n, RUN); miscompares++; end
    vectors++; if (pass !== 1'b1) begin $display("FAIL midstart_pass: got %b want 1", pass); miscompares++; end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    pulse_start();
    repeat (9) tick();
    vectors++; if (err !== 4'd1 || busy !== 1'b1) begin $display("FAIL midreset_pre: got err=%0d busy=%b want 1 1", err, busy); miscompares++; end
    reset = 1'b1; start = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin $display("FAIL midreset_flags: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass); miscompares++; end
    vectors++; if (err !== 4'd0 || ffv !== 1'b0 || ffvec !== 3'd0) begin $display("FAIL midreset_ff: got err=%0d ffv=%b vec=%0d want 0 0 0", err, ffv, ffvec); miscompares++; end
    vectors++; if (dut_in !== 3'd0) begin $display("FAIL midreset_dut_in: got %0d want 0", dut_in); miscompares++; end
    reset = 1'b0; start = 1'b0;
    tick(); tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL midreset_idle: got busy=%b done=%b want 0 0", busy, done); miscompares++; end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    test_reset();
    test_good_run();
    test_stuck(1, 4'd5, 3'd1);
    test_stuck(2, 4'd3, 3'd0);
    test_restart_from_done();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
